// File: rtl/multicycle_cpu_core.sv
// Multi-cycle MIPS-style core: loadable instruction memory, register file,
// branches/jumps, halt and sticky illegal-instruction flag; 4 cycles per instruction.
module multicycle_cpu_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 5,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] result,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              retire,
  output logic              illegal
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned DEPTH = 2**PC_W;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t            state;
  logic [31:0]       imem [DEPTH];
  logic [31:0]       fetch_q;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] rf [NREG];
  logic [4:0]        wb_addr;
  logic              wb_en;
  logic              halt_q;
  logic [PC_W-1:0]   npc;
  logic              idle_or_halt;

  logic [DATA_W-1:0] ex_res;
  logic              ex_wen;
  logic [4:0]        ex_waddr;
  logic [PC_W-1:0]   ex_npc;
  logic              ex_ill;
  logic              ex_halt;

  logic [5:0]        op, fn;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sx, imm_zx;
  logic [SH_W-1:0]   sh;
  logic [PC_W-1:0]   pc_inc;
  logic              unused_rs;

  assign idle_or_halt = (state == S_IDLE) || (state == S_HALT);

  // Register read: r0 and out-of-range indices read as zero.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [4:0] idx);
    if ((idx != 5'd0) && (32'(idx) < NREG)) return rf[idx];
    else return '0;
  endfunction

  assign dbg_data = rd_reg(dbg_addr);

  // Instruction memory is never reset so programs survive rst.
  always_ff @(posedge clk) begin
    if (load_en && idle_or_halt) imem[load_addr] <= load_data;
    if (state == S_FETCH) fetch_q <= imem[pc];
  end

  assign op        = ir[31:26];
  assign fn        = ir[5:0];
  assign imm       = ir[15:0];
  assign imm_sx    = DATA_W'($signed(imm));
  assign imm_zx    = DATA_W'(imm);
  assign sh        = b_q[SH_W-1:0];
  assign pc_inc    = pc + PC_W'(1);
  assign unused_rs = ^ir[25:21];

  // Execute: result, destination and next pc for the latched instruction.
  always_comb begin
    ex_res   = result;
    ex_wen   = 1'b0;
    ex_waddr = ir[15:11];
    ex_npc   = pc_inc;
    ex_ill   = 1'b0;
    ex_halt  = 1'b0;
    case (op)
      6'd0: begin
        ex_wen = 1'b1;
        case (fn)
          6'd32: ex_res = a_q + b_q;
          6'd34: ex_res = a_q - b_q;
          6'd36: ex_res = a_q & b_q;
          6'd37: ex_res = a_q | b_q;
          6'd38: ex_res = a_q ^ b_q;
          6'd42: ex_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
          6'd0:  ex_res = a_q << sh;
          6'd2:  ex_res = a_q >> sh;
          default: begin
            ex_wen = 1'b0;
            ex_ill = 1'b1;
          end
        endcase
      end
      6'd15: begin ex_wen = 1'b1; ex_waddr = ir[20:16]; ex_res = a_q + imm_sx; end
      6'd12: begin ex_wen = 1'b1; ex_waddr = ir[20:16]; ex_res = a_q & imm_zx; end
      6'd13: begin ex_wen = 1'b1; ex_waddr = ir[20:16]; ex_res = a_q | imm_zx; end
      6'd14: begin ex_wen = 1'b1; ex_waddr = ir[20:16]; ex_res = a_q ^ imm_zx; end
      6'd10, 6'd11: begin
        ex_res = (((a_q == b_q) ? 1'b1 : 1'b0) ^ op[0]) ? DATA_W'(1) : '0;
        if (ex_res[0]) ex_npc = PC_W'(32'(pc) + 32'd1 + 32'($signed(imm)));
      end
      6'd17: ex_npc = ir[PC_W-1:0];
      6'd63: begin ex_halt = 1'b1; ex_npc = pc; end
      default: ex_ill = 1'b1;
    endcase
  end

  // Sequencer: IDLE/HALT -> FETCH -> DECODE -> EXEC -> WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      result  <= '0;
      retire  <= 1'b0;
      illegal <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      npc     <= '0;
      halt_q  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            illegal <= 1'b0;
            busy    <= 1'b1;
            halted  <= 1'b0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir    <= fetch_q;
          a_q   <= rd_reg(fetch_q[25:21]);
          b_q   <= rd_reg(fetch_q[20:16]);
          state <= S_EXEC;
        end
        S_EXEC: begin
          result  <= ex_res;
          wb_en   <= ex_wen;
          wb_addr <= ex_waddr;
          npc     <= ex_npc;
          halt_q  <= ex_halt;
          if (ex_ill) illegal <= 1'b1;
          retire  <= 1'b1;
          state   <= S_WB;
        end
        S_WB: begin
          pc <= npc;
          if (halt_q) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file: reset to reg[i]=i; writes to r0 or beyond NREG are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= DATA_W'(i);
    end else if ((state == S_WB) && wb_en && (wb_addr != 5'd0) && (32'(wb_addr) < NREG)) begin
      rf[wb_addr] <= result;
    end
  end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core: loads small programs and checks
// results, pc sequencing, flags and register contents against hand-computed values.
module tb_multicycle_cpu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] result;
  logic [4:0]  pc;
  logic        busy, halted, retire, illegal;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  localparam logic [31:0] HALT_W = 32'hFC000000;

  multicycle_cpu_core #(.DATA_W(32), .PC_W(5), .NREG(32)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .result(result), .pc(pc), .busy(busy),
    .halted(halted), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_retire(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!retire && c < 20);
    chk("retire_seen", 32'(retire), 32'd1);
  endtask

  logic [31:0] alu_prog [11];
  logic [31:0] alu_exp  [10];

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; dbg_addr = '0;
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    chk_reg("rst_r5", 5'd5, 32'd5);
    chk_reg("rst_r0", 5'd0, 32'd0);
    for (int i = 0; i < 32; i++) load(5'(i), 32'h0);

    // add r3=r1+r2; halt
    load(5'd0, 32'h00221820);
    load(5'd1, HALT_W);
    do_start();
    chk("add_busy", 32'(busy), 32'd1);
    wait_retire(cyc);
    chk("add_latency", 32'(cyc), 32'd3);
    chk("add_result", result, 32'd3);
    chk("add_pc", 32'(pc), 32'd0);
    tick();
    chk_reg("add_r3", 5'd3, 32'd3);
    wait_retire(cyc);
    chk("halt_pc_wb", 32'(pc), 32'd1);
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_pc", 32'(pc), 32'd1);

    // sub wrap and addi sign extension
    load(5'd0, 32'h00222022);
    load(5'd1, 32'h3CA6FFFF);
    load(5'd2, HALT_W);
    do_start();
    wait_retire(cyc);
    chk("sub_result", result, 32'hFFFFFFFF);
    wait_retire(cyc);
    chk("addi_result", result, 32'd4);
    wait_retire(cyc);
    tick();
    chk("sub_halted", 32'(halted), 32'd1);
    chk_reg("sub_r4", 5'd4, 32'hFFFFFFFF);
    chk_reg("addi_r6", 5'd6, 32'd4);

    // beq r1,r1,+2 skips words 1 and 2
    load(5'd0, 32'h28210002);
    load(5'd1, 32'h3C070055);
    load(5'd2, 32'h3C070055);
    load(5'd3, HALT_W);
    do_start();
    wait_retire(cyc);
    chk("beq_result", result, 32'd1);
    chk("beq_pc", 32'(pc), 32'd0);
    wait_retire(cyc);
    chk("beq_target_pc", 32'(pc), 32'd3);
    tick();
    chk("beq_halted", 32'(halted), 32'd1);
    chk_reg("beq_r7", 5'd7, 32'd7);

    // bne r1,r1 falls through
    load(5'd0, 32'h2C210002);
    load(5'd1, HALT_W);
    do_start();
    wait_retire(cyc);
    chk("bne_result", result, 32'd0);
    wait_retire(cyc);
    chk("bne_pc", 32'(pc), 32'd1);
    tick();
    chk("bne_halted", 32'(halted), 32'd1);

    // j 5
    load(5'd0, 32'h44000005);
    load(5'd5, HALT_W);
    do_start();
    wait_retire(cyc);
    chk("j_result", result, 32'd0);
    tick();
    chk("j_fetch_pc", 32'(pc), 32'd5);
    wait_retire(cyc);
    tick();
    chk("j_halt_pc", 32'(pc), 32'd5);

    // illegal opcode and funct: no writes, flag sticky until start
    load(5'd0, 32'h08A6FFFF);
    load(5'd1, 32'h00A6583F);
    load(5'd2, HALT_W);
    do_start();
    chk("ill_clear0", 32'(illegal), 32'd0);
    wait_retire(cyc);
    chk("ill_op_flag", 32'(illegal), 32'd1);
    tick();
    chk("ill_op_pc", 32'(pc), 32'd1);
    wait_retire(cyc);
    wait_retire(cyc);
    tick();
    chk("ill_sticky", 32'(illegal), 32'd1);
    chk_reg("ill_r6", 5'd6, 32'd4);
    chk_reg("ill_r11", 5'd11, 32'd11);
    load_en = 1'b1; load_addr = 5'd0; load_data = HALT_W; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk("ill_cleared", 32'(illegal), 32'd0);
    wait_retire(cyc);
    tick();
    chk("ldst_halt_pc", 32'(pc), 32'd0);
    chk("ldst_halted", 32'(halted), 32'd1);

    // j 31 then word 31 wraps to 0; a load while busy is ignored
    load(5'd0, 32'h4400001F);
    do_start();
    wait_retire(cyc);
    load(5'd31, HALT_W);
    wait_retire(cyc);
    chk("wrap_pc31", 32'(pc), 32'd31);
    tick();
    chk("wrap_pc0", 32'(pc), 32'd0);
    chk("busy_load_ignored", 32'(halted), 32'd0);
    chk("wrap_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_stop_busy", 32'(busy), 32'd0);

    // reset during EXEC of add r3=r1+r1 aborts the write
    load(5'd0, 32'h00000000);
    load(5'd1, 32'h00211820);
    load(5'd2, HALT_W);
    do_start();
    wait_retire(cyc);
    tick(); tick(); tick();
    chk("exec_pc", 32'(pc), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_pc", 32'(pc), 32'd0);
    chk_reg("async_rst_r3", 5'd3, 32'd3);
    tick();
    rst = 1'b0;
    do_start();
    wait_retire(cyc);
    wait_retire(cyc);
    wait_retire(cyc);
    tick();
    chk("rerun_pc", 32'(pc), 32'd2);
    chk_reg("rerun_r3", 5'd3, 32'd2);

    // load+start together in HALT executes the new word
    load_en = 1'b1; load_addr = 5'd0; load_data = 32'h3C0A00AB; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    wait_retire(cyc);
    chk("ldst_result", result, 32'h000000AB);
    wait_retire(cyc);
    wait_retire(cyc);
    tick();
    chk_reg("ldst_r10", 5'd10, 32'h000000AB);

    // ALU coverage program
    alu_prog = '{32'h00A65824, 32'h00A66025, 32'h00A66826, 32'h00227822, 32'h01E1702A,
                 32'h00A28000, 32'h01E48802, 32'h31F28001, 32'h34138000, 32'h39F400FF, HALT_W};
    alu_exp  = '{32'h4, 32'h7, 32'h3, 32'hFFFFFFFF, 32'h1,
                 32'h14, 32'h0FFFFFFF, 32'h8001, 32'h8000, 32'hFFFFFF00};
    for (int i = 0; i < 11; i++) load(5'(i), alu_prog[i]);
    do_start();
    for (int i = 0; i < 10; i++) begin
      wait_retire(cyc);
      chk($sformatf("alu_%0d", i), result, alu_exp[i]);
    end
    wait_retire(cyc);
    tick();
    chk("alu_halted", 32'(halted), 32'd1);
    chk_reg("alu_r14", 5'd14, 32'd1);
    chk_reg("alu_r18", 5'd18, 32'h8001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
